// File: rtl/sat_add_rr_arbiter_if.sv
// Operand/result bundle for sat_add_rr_arbiter: N_REQ requester lanes in, one tagged result out.
// A transfer happens on a rising clk edge where valid and ready are both 1; a producer holds valid and data stable until it sees ready.
interface sat_add_rr_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   res_valid;
  logic                   res_ready;
  logic [WIDTH-1:0]       res_sum;
  logic [ID_W-1:0]        res_id;
  logic                   res_sat;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_id, res_sat
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_id, res_sat
  );
endinterface

// File: rtl/sat_add_rr_arbiter.sv
// Round-robin shared signed saturating adder with a single registered, tagged result slot.
// Optional SAT_ADD_STATS_EN adds saturating sat_count / busy_cycles counters.
module sat_add_rr_arbiter #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  sat_add_rr_arbiter_if.slave bus
`ifdef SAT_ADD_STATS_EN
  ,
  output logic [15:0]         sat_count,
  output logic [15:0]         busy_cycles
`endif
);
  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]  ptr;
  logic             slot_free;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] raw;
  logic             ovf;
  logic [WIDTH-1:0] sat_sum;

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  assign slot_free = !bus.res_valid || bus.res_ready;

  // Scan from the farthest candidate back to ptr so the nearest valid requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (!rst && slot_free) begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        if (bus.req_valid[rr_idx(ptr, k)]) begin
          grant_valid = 1'b1;
          grant_idx   = rr_idx(ptr, k);
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant_valid) bus.req_ready[grant_idx] = 1'b1;
  end

  assign op_a = bus.req_a[int'(grant_idx) * WIDTH +: WIDTH];
  assign op_b = bus.req_b[int'(grant_idx) * WIDTH +: WIDTH];
  assign raw  = op_a + op_b;
  // Overflow only possible when both operands share a sign and the wrapped sum flips it.
  assign ovf  = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (raw[WIDTH-1] != op_a[WIDTH-1]);

  always_comb begin
    sat_sum = raw;
    if (ovf) sat_sum = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res_valid <= 1'b0;
      bus.res_sum   <= '0;
      bus.res_id    <= '0;
      bus.res_sat   <= 1'b0;
      ptr           <= '0;
    end else if (grant_valid) begin
      bus.res_valid <= 1'b1;
      bus.res_sum   <= sat_sum;
      bus.res_id    <= grant_idx;
      bus.res_sat   <= ovf;
      ptr           <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (bus.res_valid && bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

`ifdef SAT_ADD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count   <= '0;
      busy_cycles <= '0;
    end else begin
      if (grant_valid && ovf && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
      if (bus.res_valid && !bus.res_ready && busy_cycles != 16'hFFFF)
        busy_cycles <= busy_cycles + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sat_add_rr_arbiter.sv
// Bench for sat_add_rr_arbiter: reset, vector table, round-robin/backpressure/reset sequences,
// randomized traffic against a queue-based model; stats counters when SAT_ADD_STATS_EN is defined.
module tb_sat_add_rr_arbiter;
  localparam int W   = 4;
  localparam int N   = 4;
  localparam int IDW = $clog2(N);
  localparam int EW  = 1 + IDW + W;

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   sum;
    logic           sat;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sat_add_rr_arbiter_if #(.WIDTH(W), .N_REQ(N)) bus ();

`ifdef SAT_ADD_STATS_EN
  logic [15:0] sat_count;
  logic [15:0] busy_cycles;
`endif

  sat_add_rr_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SAT_ADD_STATS_EN
    ,
    .sat_count   (sat_count),
    .busy_cycles (busy_cycles)
`endif
  );

  int             n_tests = 0;
  int             n_fail  = 0;
  logic [EW-1:0]  exp_q[$];
  logic           pend[N];
  logic [W-1:0]   pa[N];
  logic [W-1:0]   pb[N];
  int             next_rr;
  vec_t           vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input int i, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_valid[i]     = v;
    bus.req_a[i*W +: W]  = a;
    bus.req_b[i*W +: W]  = b;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    bus.res_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    exp_q.delete();
    next_rr = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  // ---------------- scoreboard / model ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Signed sum computed in plain integers, then clamped to the representable range.
  function automatic logic [EW-1:0] model(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    int lo;
    int hi;
    logic sat;
    lo  = -(2 ** (W - 1));
    hi  = 2 ** (W - 1) - 1;
    s   = int'($signed(a)) + int'($signed(b));
    sat = 1'b0;
    if (s > hi) begin
      s = hi;
      sat = 1'b1;
    end else if (s < lo) begin
      s = lo;
      sat = 1'b1;
    end
    return {sat, IDW'(id), W'(s)};
  endfunction

  initial begin
    int g;
    int exp_ready;
    logic [W-1:0] held_sum;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;
    @(negedge clk);

    // Reset state: requests present but nothing granted while rst is high.
    rst = 1'b1;
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    cycle();
    #1;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_sum",   bus.res_sum,   0);
    chk("rst_res_id",    bus.res_id,    0);
    chk("rst_res_sat",   bus.res_sat,   0);
    chk("rst_req_ready", bus.req_ready, 0);
    do_reset();

    // ---------------- vector table ----------------
    vecs[0] = '{id: 2'd1, a: 4'h3, b: 4'h2, sum: 4'h5, sat: 1'b0};
    vecs[1] = '{id: 2'd2, a: 4'h7, b: 4'h1, sum: 4'h7, sat: 1'b1};
    vecs[2] = '{id: 2'd3, a: 4'h8, b: 4'hF, sum: 4'h8, sat: 1'b1};
    vecs[3] = '{id: 2'd0, a: 4'h8, b: 4'h7, sum: 4'hF, sat: 1'b0};
    vecs[4] = '{id: 2'd1, a: 4'hF, b: 4'hF, sum: 4'hE, sat: 1'b0};
    vecs[5] = '{id: 2'd2, a: 4'h4, b: 4'h4, sum: 4'h7, sat: 1'b1};
    vecs[6] = '{id: 2'd3, a: 4'hB, b: 4'hC, sum: 4'h8, sat: 1'b1};
    vecs[7] = '{id: 2'd0, a: 4'hC, b: 4'hC, sum: 4'h8, sat: 1'b0};
    vecs[8] = '{id: 2'd1, a: 4'h6, b: 4'hE, sum: 4'h4, sat: 1'b0};
    vecs[9] = '{id: 2'd2, a: 4'h0, b: 4'h0, sum: 4'h0, sat: 1'b0};
    for (int v = 0; v < 10; v++) begin
      clear_reqs();
      drive_req(int'(vecs[v].id), 1'b1, vecs[v].a, vecs[v].b);
      bus.res_ready = 1'b1;
      #1;
      chk("vec_req_ready", bus.req_ready, 32'(1) << vecs[v].id);
      cycle();
      clear_reqs();
      #1;
      chk("vec_res_valid", bus.res_valid, 1);
      chk("vec_res_sum",   bus.res_sum,   vecs[v].sum);
      chk("vec_res_id",    bus.res_id,    vecs[v].id);
      chk("vec_res_sat",   bus.res_sat,   vecs[v].sat);
    end

    // ---------------- round robin, all requesters valid ----------------
    do_reset();
    for (int i = 0; i < N; i++) drive_req(i, 1'b1, W'(i), W'(1));
    bus.res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", bus.req_ready, 32'(1) << (k % N));
      if (k > 0) begin
        chk("rr_res_valid", bus.res_valid, 1);
        chk("rr_res_id",    bus.res_id,    (k - 1) % N);
      end
      cycle();
    end

    // ---------------- backpressure: result for requester 0 is held ----------------
    bus.res_ready = 1'b0;
    held_sum = W'(1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_res_valid", bus.res_valid, 1);
      chk("bp_res_id",    bus.res_id,    0);
      chk("bp_res_sum",   bus.res_sum,   held_sum);
      cycle();
    end
    bus.res_ready = 1'b1;
    #1;
    chk("bp_release_grant", bus.req_ready, 4'b0010);
    cycle();
    #1;
    chk("bp_nobubble_valid", bus.res_valid, 1);
    chk("bp_nobubble_id",    bus.res_id,    1);
    chk("bp_nobubble_sum",   bus.res_sum,   2);

    // ---------------- reset while a result is stalled ----------------
    bus.res_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", bus.req_ready, 0);
    cycle();
    #1;
    chk("mid_rst_res_valid", bus.res_valid, 0);
    chk("mid_rst_res_sum",   bus.res_sum,   0);
    rst = 1'b0;
    bus.res_ready = 1'b1;
    #1;
    chk("mid_rst_first_grant", bus.req_ready, 4'b0001);
    cycle();
    #1;
    chk("mid_rst_res_id", bus.res_id, 0);

    // ---------------- randomized traffic vs model ----------------
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          pa[i]   = W'($urandom_range(0, 2 ** W - 1));
          pb[i]   = W'($urandom_range(0, 2 ** W - 1));
        end
        drive_req(i, pend[i], pa[i], pb[i]);
      end
      bus.res_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_res_valid", bus.res_valid, exp_q.size() != 0);
      if (exp_q.size() != 0)
        chk("rnd_result", {bus.res_sat, bus.res_id, bus.res_sum}, exp_q[0]);
      g = -1;
      if (exp_q.size() == 0 || bus.res_ready) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && pend[(next_rr + k) % N]) g = (next_rr + k) % N;
        end
      end
      exp_ready = (g >= 0) ? (1 << g) : 0;
      chk("rnd_req_ready", bus.req_ready, exp_ready);
      if (exp_q.size() != 0 && bus.res_ready) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back(model(g, pa[g], pb[g]));
        pend[g] = 1'b0;
        next_rr = (g + 1) % N;
      end
      cycle();
    end
    clear_reqs();
    bus.res_ready = 1'b1;
    #1;
    chk("rnd_tail_valid", bus.res_valid, exp_q.size() != 0);
    if (exp_q.size() != 0)
      chk("rnd_tail_result", {bus.res_sat, bus.res_id, bus.res_sum}, exp_q[0]);
    cycle();

`ifdef SAT_ADD_STATS_EN
    // ---------------- statistics counters ----------------
    do_reset();
    #1;
    chk("stats_rst_sat",  sat_count,   0);
    chk("stats_rst_busy", busy_cycles, 0);
    bus.res_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      clear_reqs();
      if (v < 5) drive_req(0, 1'b1, 4'h7, 4'h7);
      else       drive_req(0, 1'b1, 4'h1, 4'h2);
      cycle();
    end
    clear_reqs();
    #1;
    chk("stats_sat_count", sat_count, 5);
    drive_req(1, 1'b1, 4'h1, 4'h1);
    cycle();
    clear_reqs();
    bus.res_ready = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    bus.res_ready = 1'b1;
    cycle();
    #1;
    chk("stats_busy_cycles", busy_cycles, 4);
    chk("stats_sat_after",   sat_count,   5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sat_add_rr_arbiter.md
Name: sat_add_rr_arbiter

Overview:
- Shares one signed saturating adder among N_REQ requesters using round-robin arbitration.
- Each requester presents an (a, b) operand pair with a valid/ready handshake.
- The granted pair is added with saturation and captured in a single output register, which carries a valid/ready handshake toward the consumer.
- Sits in the arithmetic section between operand producers and a common result sink; tags each result with the requester index.

Parameters:
- WIDTH, 4, operand/result width in bits, two's complement, WIDTH >= 2.
- N_REQ, 4, number of requesters, N_REQ >= 2.
- ID_W, $clog2(N_REQ), width of the requester index (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  bit i: requester i presents an operand pair.
- req_ready  output  N_REQ  bit i: requester i's pair is accepted this cycle (one-hot or zero).
- req_a  input  N_REQ*WIDTH  operand a of requester i in bits [i*WIDTH +: WIDTH].
- req_b  input  N_REQ*WIDTH  operand b of requester i, same packing as req_a.
- res_valid  output  1  output register holds a result.
- res_ready  input  1  consumer accepts the result this cycle.
- res_sum  output  WIDTH  saturated signed sum.
- res_id  output  ID_W  index of the requester that produced res_sum.
- res_sat  output  1  1 when res_sum was clamped.

Behaviour:
- Reset: while rst=1, res_valid=0, res_sum=0, res_id=0, res_sat=0, rr pointer=0, req_ready=0. Reset mid-transaction discards the held result with no output.
- Slot free condition: slot_free = !res_valid || res_ready.
- Arbitration (combinational):
  - Only when slot_free, grant the first i with req_valid[i]=1, searching ptr, ptr+1, … modulo N_REQ.
  - req_ready = one-hot grant, or all zero when there is no request or the slot is not free.
  - req_ready never depends combinationally on req_a or req_b.
- Pointer update: on an accepted grant to index g, ptr <= (g == N_REQ-1) ? 0 : g+1. Otherwise ptr holds.
- Latency: a pair accepted in cycle t appears with res_valid=1 in cycle t+1. Throughput is one result per cycle when res_ready stays high.
- Output hold:
  - While res_valid=1 and res_ready=0, res_sum, res_id and res_sat are stable and no grant is issued.
  - When res_valid=1 and res_ready=1 and a grant occurs in the same cycle, the register loads the new result, so res_valid stays 1.
  - When res_valid=1 and res_ready=1 with no grant, res_valid <= 0.
- Arithmetic:
  - raw = a + b, computed mod 2^WIDTH.
  - Overflow when sign(a) == sign(b) and sign(raw) != sign(a).
  - On overflow, result = a negative ? minimum negative (1 followed by zeros) : maximum positive (0 followed by ones), and res_sat=1.
  - Otherwise result = raw and res_sat=0.
  - Mixed-sign operands never saturate.
- Fairness: a requester that holds req_valid high is granted within N_REQ accepted transactions.
- Requester protocol: requesters must hold valid and data stable until they see ready. The block does not check this.

Optional Feature:
- Macro: SAT_ADD_STATS_EN.
- When defined, adds two outputs:
  - sat_count, output, 16 bits: counts results loaded with res_sat=1. Increments once per such load and saturates at 16'hFFFF without wrapping. Resets to 0.
  - busy_cycles, output, 16 bits: counts cycles in which res_valid=1 and res_ready=0. Also saturates at 16'hFFFF and resets to 0.
- When undefined, neither port exists and all other behaviour is identical.

Test Plan:
- Single requester, WIDTH=4, N_REQ=4: req 1 sends a=3, b=2 with res_ready=1 → next cycle res_valid=1, res_sum=5, res_id=1, res_sat=0.
- Saturation cases:
  - a=7, b=1 → res_sum=4'b0111, res_sat=1.
  - a=-8, b=-1 → res_sum=4'b1000, res_sat=1.
  - a=-8, b=7 → res_sum=-1, res_sat=0.
- Round robin: all four requesters hold valid, res_ready=1 → grants 0, 1, 2, 3, 0 on consecutive cycles, and res_id follows one cycle later.
- Backpressure: hold res_ready=0 for 3 cycles with a result pending → res_* stable, req_ready all 0. Raise res_ready → the next grant and the drain happen in the same cycle, with no bubble.
- Reset mid-operation: assert rst while res_valid=1 and res_ready=0 → next cycle res_valid=0, ptr=0. After release, requester 0 wins first among all-valid requesters.
- With SAT_ADD_STATS_EN: 5 saturating and 3 non-saturating results → sat_count=5. Stalling 4 cycles → busy_cycles=4.
